// File: rtl/dma_bus_arbiter_pkg.sv
// Shared definitions for the video DMA bus arbiter: FSM state encoding,
// RAM address width and state decode helpers.
package dma_bus_arbiter_pkg;

  localparam int RAM_AW = 17;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_SETTLE  = 3'd2;
  localparam logic [2:0] ST_GRANT   = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  // RAM address/write-enable belong to the CRTC only while settling or granted.
  function automatic logic is_crtc_mux(input logic [2:0] st);
    return (st == ST_SETTLE) || (st == ST_GRANT);
  endfunction

  function automatic logic holds_busrq(input logic [2:0] st);
    return (st == ST_REQ) || (st == ST_SETTLE) || (st == ST_GRANT);
  endfunction

endpackage

// File: rtl/dma_bus_arbiter_sat_counter16.sv
// 16-bit up-counter that sticks at 16'hFFFF; clear has priority over increment.
module sat_counter16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 16'd0;
    end else if (inc && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/dma_bus_arbiter.sv
// CRTC-side DMA responder: takes the Z80 bus via BUSRQ/BUSAK, steers main-RAM
// address/write-enable to the CRTC, returns registered read data, counts bus steals.
module dma_bus_arbiter
  import dma_bus_arbiter_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int MAX_HOLD   = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              crtc_busreq,
  output logic              crtc_busack,
  input  logic [RAM_AW-1:0] crtc_adr,
  output logic [7:0]        crtc_data,
  output logic              cpu_busrq_n,
  input  logic              cpu_busak_n,
  input  logic [RAM_AW-1:0] cpu_adr,
  input  logic              cpu_we,
  output logic [RAM_AW-1:0] ram_adr,
  output logic              ram_we,
  input  logic [7:0]        ram_q,
  input  logic              stat_clr,
  output logic [15:0]       steal_cnt,
  output logic              timeout
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);
  localparam logic [9:0] HOLD_LAST   = 10'(MAX_HOLD - 1);

  logic [2:0] state_q,   state_d;
  logic [3:0] settle_q,  settle_d;
  logic [9:0] hold_q,    hold_d;
  logic       busack_q,  busack_d;
  logic       busrq_n_q, busrq_n_d;
  logic [7:0] data_q,    data_d;
  logic       timeout_q, timeout_d;
  logic       timeout_set;
  logic       mux_crtc;

  // Mux select decodes the state register only, so it never glitches on inputs.
  assign mux_crtc = is_crtc_mux(state_q);

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    hold_d      = hold_q;
    timeout_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (crtc_busreq) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!crtc_busreq) begin
          state_d = ST_RELEASE;
        end else if (!cpu_busak_n) begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (settle_q == 4'd0) begin
          state_d = ST_GRANT;
          hold_d  = 10'd0;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      ST_GRANT: begin
        if (!crtc_busreq) begin
          state_d = ST_RELEASE;
        end else if (hold_q == HOLD_LAST) begin
          state_d     = ST_RELEASE;
          timeout_set = 1'b1;
        end else begin
          hold_d = hold_q + 10'd1;
        end
      end
      ST_RELEASE: begin
        // Waiting for busreq low too stops a timed-out CRTC from re-grabbing the bus.
        if (cpu_busak_n && !crtc_busreq) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busack_d  = (state_q == ST_GRANT);
    busrq_n_d = !holds_busrq(state_q);
    data_d    = mux_crtc ? ram_q : data_q;
    timeout_d = timeout_set ? 1'b1 : (stat_clr ? 1'b0 : timeout_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      settle_q  <= 4'd0;
      hold_q    <= 10'd0;
      busack_q  <= 1'b0;
      busrq_n_q <= 1'b1;
      data_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      hold_q    <= hold_d;
      busack_q  <= busack_d;
      busrq_n_q <= busrq_n_d;
      data_q    <= data_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter16 u_steal_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (stat_clr),
    .inc   (!cpu_busak_n),
    .count (steal_cnt)
  );

  assign ram_adr     = mux_crtc ? crtc_adr : cpu_adr;
  assign ram_we      = !mux_crtc && cpu_we;
  assign crtc_busack = busack_q;
  assign cpu_busrq_n = busrq_n_q;
  assign crtc_data   = data_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Scoreboard bench for dma_bus_arbiter: expectations are queued as stimulus is
// applied and drained against the DUT outputs #1 after the clock edge.
module tb_dma_bus_arbiter;

  localparam int SETTLE_CYC = 2;
  localparam int MAX_HOLD   = 16;

  logic        clk;
  logic        reset;
  logic        crtc_busreq;
  logic        crtc_busack;
  logic [16:0] crtc_adr;
  logic [7:0]  crtc_data;
  logic        cpu_busrq_n;
  logic        cpu_busak_n;
  logic [16:0] cpu_adr;
  logic        cpu_we;
  logic [16:0] ram_adr;
  logic        ram_we;
  logic [7:0]  ram_q;
  logic        stat_clr;
  logic [15:0] steal_cnt;
  logic        timeout;

  dma_bus_arbiter #(
    .SETTLE_CYC (SETTLE_CYC),
    .MAX_HOLD   (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .crtc_busreq (crtc_busreq),
    .crtc_busack (crtc_busack),
    .crtc_adr    (crtc_adr),
    .crtc_data   (crtc_data),
    .cpu_busrq_n (cpu_busrq_n),
    .cpu_busak_n (cpu_busak_n),
    .cpu_adr     (cpu_adr),
    .cpu_we      (cpu_we),
    .ram_adr     (ram_adr),
    .ram_we      (ram_we),
    .ram_q       (ram_q),
    .stat_clr    (stat_clr),
    .steal_cnt   (steal_cnt),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned steal_exp = 0;

  typedef enum int {K_BUSACK, K_BUSRQ_N, K_DATA, K_STEAL, K_TMO, K_ADR, K_WE} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] exp;
    string       tag;
  } exp_t;
  exp_t sb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("[%0t] ok %s = %0h", $time, tag, obs);
    end
  endtask

  task automatic expect_val(input string tag, input kind_t k, input logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.exp  = v;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] observe(input kind_t k);
    case (k)
      K_BUSACK:  return {31'd0, crtc_busack};
      K_BUSRQ_N: return {31'd0, cpu_busrq_n};
      K_DATA:    return {24'd0, crtc_data};
      K_STEAL:   return {16'd0, steal_cnt};
      K_TMO:     return {31'd0, timeout};
      K_ADR:     return {15'd0, ram_adr};
      K_WE:      return {31'd0, ram_we};
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic drain();
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check_eq(e.tag, observe(e.kind), e.exp);
    end
  endtask

  // One clock: update the steal-count model from the inputs the edge samples.
  task automatic tick();
    if (stat_clr) steal_exp = 0;
    else if (!cpu_busak_n && steal_exp != 32'hFFFF) steal_exp++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected $finish");
    $fatal(1, "global timeout");
  end

  initial begin
    reset       = 1'b1;
    crtc_busreq = 1'b0;
    crtc_adr    = 17'h0;
    cpu_busak_n = 1'b1;
    cpu_adr     = 17'h01234;
    cpu_we      = 1'b1;
    ram_q       = 8'h00;
    stat_clr    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    expect_val("rst_busack", K_BUSACK, 0);
    expect_val("rst_busrq_n", K_BUSRQ_N, 1);
    expect_val("rst_data", K_DATA, 0);
    expect_val("rst_steal", K_STEAL, 0);
    expect_val("rst_timeout", K_TMO, 0);
    expect_val("rst_ram_adr", K_ADR, 17'h01234);
    expect_val("rst_ram_we", K_WE, 1);
    drain();

    // Basic grant: BUSRQ one edge after the request is sampled
    crtc_adr    = 17'h0F300;
    crtc_busreq = 1'b1;
    tick();
    expect_val("req_busrq_n_early", K_BUSRQ_N, 1);
    drain();
    tick();
    expect_val("req_busrq_n", K_BUSRQ_N, 0);
    drain();
    repeat (3) tick();
    cpu_busak_n = 1'b0;
    begin
      int n;
      n = 0;
      while (!crtc_busack && n < 20) begin
        tick();
        n++;
        if (n == 1) begin
          expect_val("settle_ram_adr", K_ADR, 17'h0F300);
          expect_val("settle_ram_we", K_WE, 0);
          drain();
        end
      end
      // BUSAK sampled on the first edge; busack visible after edge 1+1+SETTLE_CYC
      check_eq("grant_latency", n, SETTLE_CYC + 2);
    end
    expect_val("grant_ram_adr", K_ADR, 17'h0F300);
    expect_val("grant_ram_we", K_WE, 0);
    drain();

    // Data path
    ram_q = 8'hA5;
    tick();
    expect_val("grant_data", K_DATA, 8'hA5);
    expect_val("grant_steal", K_STEAL, steal_exp);
    drain();

    // Release
    crtc_busreq = 1'b0;
    tick();
    expect_val("rel_busack_edge", K_BUSACK, 1);
    drain();
    tick();
    expect_val("rel_busack", K_BUSACK, 0);
    expect_val("rel_busrq_n", K_BUSRQ_N, 1);
    drain();
    ram_q = 8'h5A;
    tick();
    expect_val("rel_data_hold", K_DATA, 8'hA5);
    drain();
    cpu_busak_n = 1'b1;
    tick();
    expect_val("idle_ram_adr", K_ADR, 17'h01234);
    expect_val("idle_ram_we", K_WE, 1);
    drain();

    // Abort, with acknowledge arriving in the same cycle as the drop
    crtc_busreq = 1'b1;
    tick();
    tick();
    expect_val("abort_busrq_n_req", K_BUSRQ_N, 0);
    drain();
    crtc_busreq = 1'b0;
    cpu_busak_n = 1'b0;
    tick();
    tick();
    expect_val("abort_busrq_n", K_BUSRQ_N, 1);
    expect_val("abort_busack", K_BUSACK, 0);
    drain();
    repeat (3) begin
      tick();
      expect_val("abort_no_grant", K_BUSACK, 0);
      expect_val("abort_ram_adr", K_ADR, 17'h01234);
      drain();
    end
    cpu_busak_n = 1'b1;
    tick();
    crtc_busreq = 1'b1;
    tick();
    tick();
    expect_val("abort_back_idle", K_BUSRQ_N, 0);
    drain();
    crtc_busreq = 1'b0;
    tick();
    tick();
    expect_val("abort2_busrq_n", K_BUSRQ_N, 1);
    expect_val("abort2_busack", K_BUSACK, 0);
    drain();
    tick();

    // Watchdog
    crtc_busreq = 1'b1;
    tick();
    tick();
    cpu_busak_n = 1'b0;
    begin
      int hi;
      int n;
      bit seen;
      hi   = 0;
      n    = 0;
      seen = 1'b0;
      while (n < 80) begin
        tick();
        n++;
        if (crtc_busack) begin
          hi++;
          seen = 1'b1;
        end else if (seen) begin
          break;
        end
      end
      check_eq("wd_hold_cycles", hi, MAX_HOLD);
    end
    expect_val("wd_timeout", K_TMO, 1);
    expect_val("wd_busrq_n", K_BUSRQ_N, 1);
    drain();
    cpu_busak_n = 1'b1;
    repeat (4) begin
      tick();
      expect_val("wd_no_rerequest", K_BUSRQ_N, 1);
      expect_val("wd_no_regrant", K_BUSACK, 0);
      drain();
    end
    crtc_busreq = 1'b0;
    tick();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    expect_val("clr_timeout", K_TMO, 0);
    expect_val("clr_steal", K_STEAL, 0);
    drain();

    // Steal count over a 240-cycle BUSAK-low burst
    cpu_busak_n = 1'b0;
    repeat (240) tick();
    cpu_busak_n = 1'b1;
    tick();
    expect_val("burst_steal", K_STEAL, 240);
    expect_val("burst_steal_model", K_STEAL, steal_exp);
    drain();

    // Saturation, then clear coinciding with an increment
    cpu_busak_n = 1'b0;
    repeat (65535) tick();
    expect_val("sat_steal", K_STEAL, 16'hFFFF);
    drain();
    tick();
    expect_val("sat_hold", K_STEAL, 16'hFFFF);
    drain();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    expect_val("clr_wins", K_STEAL, 0);
    drain();
    cpu_busak_n = 1'b1;
    tick();

    // Asynchronous reset during GRANT
    crtc_busreq = 1'b1;
    tick();
    tick();
    cpu_busak_n = 1'b0;
    repeat (SETTLE_CYC + 2) tick();
    expect_val("pre_rst_busack", K_BUSACK, 1);
    expect_val("pre_rst_steal", K_STEAL, steal_exp);
    drain();
    #2;
    reset = 1'b1;
    #1;
    steal_exp = 0;
    expect_val("arst_busack", K_BUSACK, 0);
    expect_val("arst_busrq_n", K_BUSRQ_N, 1);
    expect_val("arst_steal", K_STEAL, 0);
    expect_val("arst_ram_adr", K_ADR, 17'h01234);
    drain();
    crtc_busreq = 1'b0;
    cpu_busak_n = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    expect_val("post_rst_busrq_n", K_BUSRQ_N, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
